mem_port_arbiter: RTL

- Shares the single RAMHelper-style memory port between the instruction-fetch requester (IF) and the load/store requester (LS).
- Accepts one request at a time over a valid/ready handshake, translates the byte address to a 64-bit word index, drives the memory port for one cycle, and returns read data or a write acknowledge to the granted requester.
- Sits between the IF/MEM pipeline stages and the memory model. MEM-stage byte selection and sign extension stay in the MEM stage.

---
 rtl/mem_port_arbiter_pkg.sv | 27 ++
 rtl/mem_port_arbiter_pick.sv | 40 ++++
 rtl/mem_port_arbiter.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter: FSM state encoding,
// requester ownership encoding, address-to-word-index translation constants.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DATA  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_LS = 1'b1;

  localparam logic [63:0] ARB_BASE_ADDR = 64'h0000_0000_8000_0000;
  localparam int unsigned ARB_IDX_SHIFT = 3;
  localparam int unsigned ARB_DATA_W    = 64;

  // Byte address to 64-bit word index; subtraction wraps, low 3 bits dropped.
  function automatic logic [63:0] word_index(input logic [63:0] addr,
                                             input logic [63:0] base);
    logic [63:0] off;
    off = addr - base;
    return off >> ARB_IDX_SHIFT;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// Two-way combinational request picker for the memory-port arbiter.
// Default: LS has fixed priority over IF.
// With MEM_PORT_ARB_RR_EN defined: the requester not granted last wins a tie.
module mem_arb_pick
  import mem_port_arbiter_pkg::*;
(
  input  logic if_valid,
  input  logic ls_valid,
`ifdef MEM_PORT_ARB_RR_EN
  input  logic last_grant,
`endif
  output logic grant_if,
  output logic grant_ls
);

  // Resolve which single requester is granted this cycle.
  always_comb begin
    grant_if = 1'b0;
    grant_ls = 1'b0;
    if (if_valid && ls_valid) begin
`ifdef MEM_PORT_ARB_RR_EN
      if (last_grant == OWN_LS) begin
        grant_if = 1'b1;
      end else begin
        grant_ls = 1'b1;
      end
`else
      grant_ls = 1'b1;
`endif
    end else if (ls_valid) begin
      grant_ls = 1'b1;
    end else if (if_valid) begin
      grant_if = 1'b1;
    end else begin
      grant_if = 1'b0;
      grant_ls = 1'b0;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one RAMHelper-style memory port between the IF and LS requesters.
// One request at a time: accept (IDLE) -> drive port (ISSUE) -> capture read
// data (DATA) -> hold response until consumed (RESP).
// Optional macro MEM_PORT_ARB_RR_EN selects round-robin arbitration.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR = ARB_BASE_ADDR,
  parameter int unsigned DATA_W    = ARB_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req_valid,
  input  logic [63:0]       if_req_addr,
  output logic              if_req_ready,
  output logic              if_resp_valid,
  output logic [DATA_W-1:0] if_resp_rdata,
  input  logic              if_resp_ready,
  input  logic              ls_req_valid,
  input  logic              ls_req_wen,
  input  logic [63:0]       ls_req_addr,
  input  logic [DATA_W-1:0] ls_req_wdata,
  input  logic [DATA_W-1:0] ls_req_wmask,
  output logic              ls_req_ready,
  output logic              ls_resp_valid,
  output logic [DATA_W-1:0] ls_resp_rdata,
  input  logic              ls_resp_ready,
  output logic              mem_en,
  output logic [63:0]       mem_idx,
  output logic              mem_wen,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_wmask,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_t        state_r;
  arb_state_t        state_s;
  logic              owner_r;
  logic              wen_r;
  logic [63:0]       idx_r;
  logic [DATA_W-1:0] wdata_r;
  logic [DATA_W-1:0] wmask_r;
  logic [DATA_W-1:0] resp_data_r;
  logic              grant_if_s;
  logic              grant_ls_s;
  logic              in_idle_s;
  logic              owner_done_s;

  assign in_idle_s = (state_r == IDLE);

`ifdef MEM_PORT_ARB_RR_EN
  logic last_grant_r;

  // Remember who won the most recent accept so the other side wins a tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_r <= OWN_IF;
    end else if (in_idle_s && (grant_if_s || grant_ls_s)) begin
      last_grant_r <= grant_ls_s;
    end
  end
`endif

  mem_arb_pick u_pick (
    .if_valid   (if_req_valid),
    .ls_valid   (ls_req_valid),
`ifdef MEM_PORT_ARB_RR_EN
    .last_grant (last_grant_r),
`endif
    .grant_if   (grant_if_s),
    .grant_ls   (grant_ls_s)
  );

  // Owner consumes its response; the other requester's ready is ignored.
  assign owner_done_s = (owner_r == OWN_LS) ? ls_resp_ready : if_resp_ready;

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic for the accept/issue/data/response sequence.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant_if_s || grant_ls_s) begin
          state_s = ISSUE;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: state_s = DATA;
      DATA:  state_s = RESP;
      RESP: begin
        if (owner_done_s) begin
          state_s = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Capture the granted request; these also drive the port between issues.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_r <= OWN_IF;
      wen_r   <= 1'b0;
      idx_r   <= 64'd0;
      wdata_r <= {DATA_W{1'b0}};
      wmask_r <= {DATA_W{1'b0}};
    end else if (in_idle_s && grant_ls_s) begin
      owner_r <= OWN_LS;
      wen_r   <= ls_req_wen;
      idx_r   <= word_index(ls_req_addr, BASE_ADDR);
      wdata_r <= ls_req_wdata;
      wmask_r <= ls_req_wmask;
    end else if (in_idle_s && grant_if_s) begin
      owner_r <= OWN_IF;
      wen_r   <= 1'b0;
      idx_r   <= word_index(if_req_addr, BASE_ADDR);
      wdata_r <= {DATA_W{1'b0}};
      wmask_r <= {DATA_W{1'b0}};
    end
  end

  // Latch read data one cycle after the read strobe; stores return zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_data_r <= {DATA_W{1'b0}};
    end else if (state_r == DATA) begin
      resp_data_r <= wen_r ? {DATA_W{1'b0}} : mem_rdata;
    end
  end

  // Decode handshake, memory-port strobes and response outputs from state.
  always_comb begin
    if_req_ready  = in_idle_s && grant_if_s;
    ls_req_ready  = in_idle_s && grant_ls_s;
    mem_en        = (state_r == ISSUE) && !wen_r;
    mem_wen       = (state_r == ISSUE) && wen_r;
    mem_idx       = idx_r;
    mem_wdata     = wdata_r;
    mem_wmask     = wmask_r;
    if_resp_valid = 1'b0;
    if_resp_rdata = {DATA_W{1'b0}};
    ls_resp_valid = 1'b0;
    ls_resp_rdata = {DATA_W{1'b0}};
    if (state_r == RESP) begin
      if (owner_r == OWN_LS) begin
        ls_resp_valid = 1'b1;
        ls_resp_rdata = resp_data_r;
      end else begin
        if_resp_valid = 1'b1;
        if_resp_rdata = resp_data_r;
      end
    end else begin
      if_resp_valid = 1'b0;
      ls_resp_valid = 1'b0;
    end
  end

endmodule
